gen_value_src: RTL and testbench
================================

# gen_value_src

Parametrised burst value source for the mode-selection family: a package enum selects, at elaboration, how data words are generated, and the block emits bursts of `BurstLen` words on a valid/ready stream after a `start` pulse. It replaces the earlier constant-per-mode output blocks with a sequential generator that has flow control, burst framing and an unsupported-mode error path. It sits between test-stimulus control logic and any stream consumer.

## Interface

Parameters:
- `Mode` — default `ModeCount`; type `gen_mode_e` from `gen_pkg`: `ModeZero=0`, `ModeConst=1`, `ModeCount=2`, `ModeLfsr=3`, `ModeDefault=100`.
- `Width` — default 8; data width, legal range 2..32.
- `BurstLen` — default 4; words per burst, at least 1.
- `Seed` — default 1; `Width` bits; initial generator value.
- `ConstVal` — default 8'hA5, zero-extended or truncated to `Width`; word used by `ModeConst`.
- `Taps` — default 8'hB8, zero-extended or truncated to `Width`; Galois LFSR feedback mask.

Ports:
- `clk`  in  1  — single clock; all logic is on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — starts a burst; sampled only in IDLE.
- `busy`  out  1  — high in RUN and DONE.
- `out_valid`  out  1  — data word valid.
- `out_ready`  in  1  — consumer accepts the word.
- `out_data`  out  `Width`  — generated word.
- `out_last`  out  1  — marks the final word of a burst; qualified by `out_valid`.
- `done`  out  1  — one-cycle pulse after the last word is transferred.
- `err`  out  1  — constant 1 for an unsupported `Mode`, otherwise 0.

## Operation

- Generator selection is done at elaboration with a generate-if chain:
  - `Mode inside {ModeZero, ModeDefault}`: word is always 0.
  - `ModeConst`: word is `ConstVal`.
  - `ModeCount`: word starts at `Seed` and increments by 1 on each transfer, modulo 2^Width; all-ones wraps to 0.
  - `ModeLfsr`: Galois right-shift LFSR. On each transfer: `s = (s >> 1) ^ (s[0] ? Taps : 0)`. If `Seed` is 0, the generator loads 1 instead.
  - Any other value: word is all-ones, `err=1`. The stream still runs normally.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when `start=1`. In the same edge: beat counter cleared and generator reloaded from `Seed`.
  - RUN: `out_valid=1`. A transfer is `out_valid && out_ready`. On a transfer the beat counter increments and the generator advances.
  - RUN -> DONE on the transfer in which `out_last=1`.
  - DONE -> IDLE unconditionally after one cycle; `done=1` during DONE.
- `out_last = (beat == BurstLen-1)` while in RUN. When `BurstLen=1`, the first word is also the last.
- `start` in RUN or DONE is ignored. A `start` held continuously starts a new burst on the first IDLE cycle.
- Each burst restarts from `Seed`; generator state is not carried between bursts.
- Beat counter width is `$clog2(BurstLen+1)`.

## Timing

- Reset values: state IDLE, `busy=0`, `out_valid=0`, `out_last=0`, `done=0`, `out_data=Seed` (0 for Zero/Default modes, `ConstVal` for Const mode, all-ones for an invalid mode). `err` is constant.
- Latency: `start` high at edge N gives `out_valid=1` and the first word in the cycle after edge N.
- Minimum burst duration is `BurstLen` cycles plus one DONE cycle. Back-to-back bursts therefore have a single idle gap: one DONE cycle, then one IDLE cycle in which `start` is sampled.
- Stall: while `out_valid && !out_ready`, `out_data` and `out_last` are held stable. `out_valid` never drops before the transfer.
- `out_data` is registered. There is no combinational path from `out_ready` to any output.
- Reset mid-burst: at the next edge everything returns to reset values. The word in flight is discarded and `done` is not pulsed.
- Simultaneous `rst` and `start`: reset wins.

## Configuration

- `GEN_VALUE_SRC_WORD_CNT_EN`
  - Defined: adds output `word_cnt` (32 bits), a free-running count of transferred words. It is cleared only by `rst`, saturates at 32'hFFFF_FFFF and is not cleared by `start`.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan

- Count mode, Width=8, Seed=8'hFE, BurstLen=4, `out_ready` tied high, `start` pulse -> data FE, FF, 00, 01; `out_last` on 01; `done` pulse one cycle later; `busy` falls the following cycle.
- LFSR mode, Width=8, Taps=8'hB8, Seed=0 -> first word 01, then 01→B8→5C→2E (words 01, B8, 5C, 2E).
- Stall: Count mode, `out_ready` low for 3 cycles on the second word -> that word is held for 3 cycles, no beat is skipped or duplicated, and the burst completes with 4 transfers.
- Mode=ModeDefault -> all words 00, `err=0`. Mode set by cast to 7 -> all words FF, `err=1`.
- `rst` asserted during the third beat -> next cycle `out_valid=0`, `busy=0`, no `done`. A new `start` replays the burst from `Seed`.
- With `GEN_VALUE_SRC_WORD_CNT_EN`: two bursts of 4 -> `word_cnt=8`. Without the macro, the bench compiles with no `word_cnt` port.

Source files
------------

// File: rtl/gen_value_src.sv
// gen_value_src -- parametrised burst value source.
//
// Purpose:
//   After a start pulse, emits a burst of BurstLen words on a valid/ready
//   stream. The word generator (zero, constant, counter, Galois LFSR, or an
//   all-ones error pattern) is chosen at elaboration by the Mode parameter.
//   Every burst restarts the generator from Seed.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      begin a burst (sampled only while idle)
//   busy       out  1      high while a burst is running or finishing
//   out_valid  out  1      out_data holds a valid word
//   out_ready  in   1      consumer accepts the current word
//   out_data   out  Width  generated word (registered)
//   out_last   out  1      final word of the burst, qualified by out_valid
//   done       out  1      one-cycle pulse after the final transfer
//   err        out  1      constant 1 when Mode is unsupported
//   word_cnt   out  32     saturating count of transferred words
//                          (only when GEN_VALUE_SRC_WORD_CNT_EN is defined)
//
// Build option:
//   GEN_VALUE_SRC_WORD_CNT_EN -- adds the word_cnt output and its counter.

package gen_pkg;
  typedef enum logic [7:0] {
    ModeZero    = 8'd0,
    ModeConst   = 8'd1,
    ModeCount   = 8'd2,
    ModeLfsr    = 8'd3,
    ModeDefault = 8'd100
  } gen_mode_e;
endpackage

module gen_value_src #(
  parameter gen_pkg::gen_mode_e Mode     = gen_pkg::ModeCount,
  parameter int unsigned        Width    = 8,
  parameter int unsigned        BurstLen = 4,
  parameter logic [Width-1:0]   Seed     = Width'(1),
  parameter logic [31:0]        ConstVal = 32'hA5,
  parameter logic [31:0]        Taps     = 32'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             err
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  localparam int unsigned        BeatW    = $clog2(BurstLen + 1);
  localparam logic [BeatW-1:0]   LastBeat = BeatW'(BurstLen - 1);
  localparam logic [Width-1:0]   ConstW   = ConstVal[Width-1:0];
  localparam logic [Width-1:0]   TapsW    = Taps[Width-1:0];

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsmState_e;

  fsmState_e        r_state;
  logic [BeatW-1:0] r_beat;
  logic [Width-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;

  logic [Width-1:0] w_loadVal;
  logic [Width-1:0] w_nextVal;
  logic             w_err;

  // Generator selection. w_loadVal is the word a burst (and reset) starts
  // from; w_nextVal is the word that follows the one currently presented.
  if (Mode == gen_pkg::ModeZero || Mode == gen_pkg::ModeDefault) begin : g_zero
    assign w_loadVal = '0;
    assign w_nextVal = '0;
    assign w_err     = 1'b0;
  end else if (Mode == gen_pkg::ModeConst) begin : g_const
    assign w_loadVal = ConstW;
    assign w_nextVal = ConstW;
    assign w_err     = 1'b0;
  end else if (Mode == gen_pkg::ModeCount) begin : g_count
    assign w_loadVal = Seed;
    assign w_nextVal = r_data + Width'(1);
    assign w_err     = 1'b0;
  end else if (Mode == gen_pkg::ModeLfsr) begin : g_lfsr
    // An all-zero LFSR state would lock up, so a zero seed loads 1.
    assign w_loadVal = (Seed == '0) ? Width'(1) : Seed;
    assign w_nextVal = (r_data >> 1) ^ (r_data[0] ? TapsW : '0);
    assign w_err     = 1'b0;
  end else begin : g_bad
    assign w_loadVal = '1;
    assign w_nextVal = '1;
    assign w_err     = 1'b1;
  end

  // Burst FSM. All stream outputs are registered here so nothing depends
  // combinationally on out_ready. out_last is precomputed for the beat that
  // will be presented next, which keeps it aligned with out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_data  <= w_loadVal;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StRun;
            r_beat  <= '0;
            r_data  <= w_loadVal;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= (BurstLen == 1);
          end
        end
        StRun: begin
          if (r_valid && out_ready) begin
            r_data <= w_nextVal;
            if (r_last) begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_beat <= r_beat + BeatW'(1);
              r_last <= ((r_beat + BeatW'(1)) == LastBeat);
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign done      = r_done;
  assign err       = w_err;

`ifdef GEN_VALUE_SRC_WORD_CNT_EN
  logic [31:0] r_wordCnt;

  // Lifetime transfer counter; only reset clears it and it sticks at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wordCnt <= '0;
    end else if (r_valid && out_ready && (r_wordCnt != 32'hFFFF_FFFF)) begin
      r_wordCnt <= r_wordCnt + 32'd1;
    end
  end

  assign word_cnt = r_wordCnt;
`endif

endmodule

// File: tb/tb_gen_value_src.sv
// Testbench for gen_value_src. Five instances share clock, reset, start and
// out_ready: counter (Seed FE), LFSR (Seed 0), ModeDefault, an invalid mode
// (7), and a single-word-burst counter (Seed 05).
module tb_gen_value_src;
  import gen_pkg::*;

  localparam int NInst = 5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic outReady;

  logic       busy     [NInst];
  logic       valid    [NInst];
  logic [7:0] data     [NInst];
  logic       last     [NInst];
  logic       doneSig  [NInst];
  logic       err      [NInst];
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
  logic [31:0] wordCnt [NInst];
`endif

  int nTests = 0;
  int nFail  = 0;
  bit checkEn = 1'b0;

  // Expected per-instance constants.
  int   blOf   [NInst] = '{4, 4, 4, 4, 1};
  logic errExp [NInst] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Model state: phase 0 idle, 1 streaming, 2 finishing; beat index; words moved.
  int          mPhase [NInst] = '{0, 0, 0, 0, 0};
  int          mBeat  [NInst] = '{0, 0, 0, 0, 0};
  logic [31:0] mCnt   [NInst] = '{0, 0, 0, 0, 0};

  logic [7:0] qXfer[$];

  always #5 clk = ~clk;

  gen_value_src #(.Mode(ModeCount), .Width(8), .BurstLen(4), .Seed(8'hFE)) uCnt (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .out_valid(valid[0]),
    .out_ready(outReady), .out_data(data[0]), .out_last(last[0]), .done(doneSig[0]),
    .err(err[0])
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
    , .word_cnt(wordCnt[0])
`endif
  );

  gen_value_src #(.Mode(ModeLfsr), .Width(8), .BurstLen(4), .Seed(8'h00), .Taps(32'hB8)) uLfsr (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .out_valid(valid[1]),
    .out_ready(outReady), .out_data(data[1]), .out_last(last[1]), .done(doneSig[1]),
    .err(err[1])
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
    , .word_cnt(wordCnt[1])
`endif
  );

  gen_value_src #(.Mode(ModeDefault), .Width(8), .BurstLen(4), .Seed(8'h33)) uDef (
    .clk(clk), .rst(rst), .start(start), .busy(busy[2]), .out_valid(valid[2]),
    .out_ready(outReady), .out_data(data[2]), .out_last(last[2]), .done(doneSig[2]),
    .err(err[2])
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
    , .word_cnt(wordCnt[2])
`endif
  );

  gen_value_src #(.Mode(gen_mode_e'(8'd7)), .Width(8), .BurstLen(4), .Seed(8'h33)) uBad (
    .clk(clk), .rst(rst), .start(start), .busy(busy[3]), .out_valid(valid[3]),
    .out_ready(outReady), .out_data(data[3]), .out_last(last[3]), .done(doneSig[3]),
    .err(err[3])
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
    , .word_cnt(wordCnt[3])
`endif
  );

  gen_value_src #(.Mode(ModeCount), .Width(8), .BurstLen(1), .Seed(8'h05)) uOne (
    .clk(clk), .rst(rst), .start(start), .busy(busy[4]), .out_valid(valid[4]),
    .out_ready(outReady), .out_data(data[4]), .out_last(last[4]), .done(doneSig[4]),
    .err(err[4])
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
    , .word_cnt(wordCnt[4])
`endif
  );

  // The k-th word of a burst for instance i, from the generator rules.
  function automatic logic [7:0] wordAt(input int i, input int k);
    logic [7:0] s;
    case (i)
      0: return 8'(32'hFE + k);
      1: begin
        s = 8'h01;
        for (int j = 0; j < k; j++) s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        return s;
      end
      2: return 8'h00;
      3: return 8'hFF;
      default: return 8'(32'h05 + k);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Drive one set of inputs ahead of the next rising edge, then return just
  // after that edge so the caller sees its effect.
  task automatic applyStimulus(input logic r, input logic st, input logic rdy);
    @(negedge clk);
    #2;
    rst      = r;
    start    = st;
    outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  // Model update: burst progress per instance, driven only by the inputs.
  always @(posedge clk) begin
    for (int i = 0; i < NInst; i++) begin
      if (rst) begin
        mPhase[i] <= 0;
        mBeat[i]  <= 0;
        mCnt[i]   <= 32'd0;
      end else begin
        case (mPhase[i])
          0: if (start) begin
            mPhase[i] <= 1;
            mBeat[i]  <= 0;
          end
          1: if (outReady) begin
            if (mCnt[i] != 32'hFFFF_FFFF) mCnt[i] <= mCnt[i] + 32'd1;
            if (mBeat[i] == blOf[i] - 1) mPhase[i] <= 2;
            else mBeat[i] <= mBeat[i] + 1;
          end
          default: mPhase[i] <= 0;
        endcase
      end
    end
  end

  // Transfers seen on the counter instance, for the stall test.
  always @(posedge clk) begin
    if (!rst && valid[0] && outReady) qXfer.push_back(data[0]);
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < NInst; i++) begin
        checkOutput("valid", i, 32'(valid[i]), 32'(mPhase[i] == 1));
        checkOutput("busy",  i, 32'(busy[i]),  32'(mPhase[i] != 0));
        checkOutput("done",  i, 32'(doneSig[i]), 32'(mPhase[i] == 2));
        checkOutput("last",  i, 32'(last[i]),  32'((mPhase[i] == 1) && (mBeat[i] == blOf[i] - 1)));
        checkOutput("err",   i, 32'(err[i]),   32'(errExp[i]));
        if (mPhase[i] == 1) checkOutput("data", i, 32'(data[i]), 32'(wordAt(i, mBeat[i])));
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
        checkOutput("wordCnt", i, wordCnt[i], mCnt[i]);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] cntExp [4];
    logic [7:0] lfsrExp[4];
    cntExp  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    lfsrExp = '{8'h01, 8'hB8, 8'h5C, 8'h2E};

    rst = 1'b1; start = 1'b0; outReady = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkEn = 1'b1;

    // Reset values.
    checkOutput("rstDataCnt", 0, 32'(data[0]), 32'hFE);
    checkOutput("rstDataDef", 2, 32'(data[2]), 32'h00);
    checkOutput("rstDataBad", 3, 32'(data[3]), 32'hFF);
    checkOutput("rstBusy",    0, 32'(busy[0]), 32'h0);
    checkOutput("rstValid",   0, 32'(valid[0]), 32'h0);
    checkOutput("errBad",     3, 32'(err[3]), 32'h1);
    checkOutput("errDef",     2, 32'(err[2]), 32'h0);

    // Burst 1: ready high, start pulse.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("cntWord",  k, 32'(data[0]), 32'(cntExp[k]));
      checkOutput("lfsrWord", k, 32'(data[1]), 32'(lfsrExp[k]));
      checkOutput("defWord",  k, 32'(data[2]), 32'h00);
      checkOutput("badWord",  k, 32'(data[3]), 32'hFF);
      checkOutput("cntLast",  k, 32'(last[0]), 32'(k == 3));
      if (k == 0) begin
        checkOutput("oneWord", 4, 32'(data[4]), 32'h05);
        checkOutput("oneLast", 4, 32'(last[4]), 32'h1);
      end
      if (k == 1) checkOutput("oneDone", 4, 32'(doneSig[4]), 32'h1);
      if (k < 3) applyStimulus(1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("doneAfterLast", 0, 32'(doneSig[0]), 32'h1);
    checkOutput("busyInDone",    0, 32'(busy[0]), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("doneOneCycle",  0, 32'(doneSig[0]), 32'h0);
    checkOutput("busyFalls",     0, 32'(busy[0]), 32'h0);

    // Burst 2: stall the second word for three cycles.
    qXfer.delete();
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stallHeld", k, 32'(data[0]), 32'hFF);
      checkOutput("stallValid", k, 32'(valid[0]), 32'h1);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stallXfers", 0, 32'(qXfer.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < qXfer.size()) checkOutput("stallWord", k, 32'(qXfer[k]), 32'(cntExp[k]));
    end
`ifdef GEN_VALUE_SRC_WORD_CNT_EN
    checkOutput("wordCnt2Bursts", 0, wordCnt[0], 32'd8);
`endif

    // Reset during the third beat, then replay from Seed.
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("thirdBeat", 0, 32'(data[0]), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("rstMidValid", 0, 32'(valid[0]), 32'h0);
    checkOutput("rstMidBusy",  0, 32'(busy[0]), 32'h0);
    checkOutput("rstMidData",  0, 32'(data[0]), 32'hFE);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rstNoDone", 0, 32'(doneSig[0]), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("replayValid", 0, 32'(valid[0]), 32'h1);
    checkOutput("replayWord",  0, 32'(data[0]), 32'hFE);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);

    // Reset and start together: reset wins.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rstWinsValid", 0, 32'(valid[0]), 32'h0);
    checkOutput("rstWinsBusy",  0, 32'(busy[0]), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Start held high: one DONE cycle and one IDLE cycle between bursts.
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("heldIdleGap", 0, 32'(busy[0]), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("heldRestart", 0, 32'(valid[0]), 32'h1);
    checkOutput("heldWord",    0, 32'(data[0]), 32'hFE);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
